// File: rtl/pg_stage64.sv
// pg_stage64 -- propagate/generate front stage of a pipelined adder/subtractor.
//
// Turns each accepted operand beat {a, b, sub, c_in, tag} into the bitwise
// propagate (p = a ^ b_eff) and generate (g = a & b_eff) vectors, plus the
// effective carry-in, and registers them for the downstream carry network.
// A two-entry elastic buffer (output register OR + skid register SR) keeps
// in_ready a pure register output, with no path from out_ready, while still
// sustaining one beat per cycle.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   a, b                WIDTH-bit operands
//   sub                 1 = a - b - borrow, 0 = a + b + carry
//   c_in                carry-in (add) or borrow-in (subtract)
//   tag                 opaque 4-bit transaction tag
//   out_valid/out_ready downstream handshake
//   p_out, g_out        registered propagate / generate vectors
//   c_out               registered effective carry-in
//   tag_out             tag of the presented beat
//
// WIDTH must be a multiple of 16 so the downstream 16-bit carry groups tile.

`timescale 1ns/1ps

module pg_stage64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  input  logic [3:0]       tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out,
  output logic             c_out,
  output logic [3:0]       tag_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // OR and SR empty
    ONE   = 2'd1,  // OR full
    TWO   = 2'd2   // OR and SR full
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c;
    logic [3:0]       tag;
  } beat_t;

  state_t           state, state_nxt;
  beat_t            beat_in, or_q, sr_q;
  logic [WIDTH-1:0] b_eff;
  logic             in_ready_q, out_valid_q;
  logic             accept, send;
  logic             load_or_in, load_or_sr, load_sr;

  // Subtraction is a + ~b + ~borrow, so p/g/carry are formed here, before
  // capture; the registers only ever hold finished terms.
  always_comb begin
    b_eff       = sub ? ~b : b;
    beat_in.p   = a ^ b_eff;
    beat_in.g   = a & b_eff;
    beat_in.c   = sub ? ~c_in : c_in;
    beat_in.tag = tag;
  end

  assign accept = in_valid & in_ready_q;
  assign send   = out_valid_q & out_ready;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    load_or_in = 1'b0;
    load_or_sr = 1'b0;
    load_sr    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          load_or_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && send) begin
          load_or_in = 1'b1;          // OR drains and refills in one edge
        end else if (accept) begin
          state_nxt  = TWO;
          load_sr    = 1'b1;          // OR is stalled, park beat in skid
        end else if (send) begin
          state_nxt  = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so accept cannot occur.
        if (send) begin
          state_nxt  = ONE;
          load_or_sr = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // in_ready/out_valid are flops loaded from the next state, so they are
  // register outputs and out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != TWO);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  // NOTE: OR and SR are two plain registers, not a RAM, so resetting them is
  // cheap; it gives all-zero outputs in reset and drops held beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q <= '0;
      sr_q <= '0;
    end else begin
      if (load_or_in) begin
        or_q <= beat_in;
      end else if (load_or_sr) begin
        or_q <= sr_q;
      end
      if (load_sr) begin
        sr_q <= beat_in;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p_out     = or_q.p;
  assign g_out     = or_q.g;
  assign c_out     = or_q.c;
  assign tag_out   = or_q.tag;

endmodule

// File: tb/tb_pg_stage64.sv
// Self-checking bench for pg_stage64: directed add/subtract, backpressure,
// streaming and asynchronous-reset cases, then a long random valid/ready run.
// Accepted beats are queued with their raw operands; each sent beat is
// popped and compared, and the sum rebuilt from p/g/c is checked against a
// plain a + b + c / a - b - c.

`timescale 1ns/1ps

module tb_pg_stage64;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub, c_in;
  logic [3:0]   tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p_out, g_out;
  logic         c_out;
  logic [3:0]   tag_out;

  pg_stage64 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .tag       (tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_out     (p_out),
    .g_out     (g_out),
    .c_out     (c_out),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [3:0]   tag;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc    = 0;
  int   n_sent   = 0;

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Sum reconstructed the way the downstream network would: sum = p ^ carry.
  function automatic logic [W-1:0] ripple_sum(input logic [W-1:0] p,
                                              input logic [W-1:0] g,
                                              input logic c);
    logic [W-1:0] s;
    logic         cc;
    cc = c;
    for (int i = 0; i < W; i++) begin
      s[i] = p[i] ^ cc;
      cc   = g[i] | (p[i] & cc);
    end
    return s;
  endfunction

  task automatic score();
    txn_t         t;
    logic [W-1:0] be, exp_sum;
    if (sb.size() == 0) begin
      check("unexpected_beat", 1, 0);
    end else begin
      t  = sb.pop_front();
      be = t.sub ? ~t.b : t.b;
      exp_sum = t.sub ? (t.a - t.b - W'(t.cin)) : (t.a + t.b + W'(t.cin));
      check("sb_p", p_out, t.a ^ be);
      check("sb_g", g_out, t.a & be);
      check("sb_c_tag", {59'd0, c_out, tag_out},
            {59'd0, t.sub ? ~t.cin : t.cin, t.tag});
      check("sb_sum", ripple_sum(p_out, g_out, c_out), exp_sum);
    end
    n_sent++;
  endtask

  // One clock: observe handshakes mid-cycle, then step to just after the edge.
  task automatic cycle();
    @(negedge clk);
    if (out_valid && out_ready) score();
    if (in_valid && in_ready) begin
      sb.push_back('{a: a, b: b, sub: sub, cin: c_in, tag: tag});
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic s,
                       input logic c, input logic [3:0] t);
    in_valid = v;
    a        = av;
    b        = bv;
    sub      = s;
    c_in     = c;
    tag      = t;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_out_valid"}, W'(out_valid), 0);
    check({pfx, "_in_ready"},  W'(in_ready),  1);
    check({pfx, "_p_out"},     p_out,         0);
    check({pfx, "_g_out"},     g_out,         0);
    check({pfx, "_c_tag"},     {59'd0, c_out, tag_out}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc;

    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'd0);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Add: 0xFF + 0x1
    out_ready = 1'b1;
    drive(1'b1, 64'h0000_0000_0000_00FF, 64'h1, 1'b0, 1'b0, 4'd3);
    cycle();
    check("add_out_valid", W'(out_valid), 1);
    check("add_p", p_out, 64'h0000_0000_0000_00FE);
    check("add_g", g_out, 64'h0000_0000_0000_0001);
    check("add_c", W'(c_out), 0);
    in_valid = 1'b0;
    cycle();

    // Subtract: 5 - 3
    drive(1'b1, 64'd5, 64'd3, 1'b1, 1'b0, 4'd4);
    cycle();
    check("sub_p", p_out, 64'hFFFF_FFFF_FFFF_FFF9);
    check("sub_g", g_out, 64'h0000_0000_0000_0004);
    check("sub_c", W'(c_out), 1);
    in_valid = 1'b0;
    cycle();
    check("sub_drained", W'(out_valid), 0);

    // Backpressure: two beats while downstream stalls
    out_ready = 1'b0;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, 4'd1);
    cycle();
    drive(1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b1, 1'b1, 4'd2);
    cycle();
    check("bp_in_ready_low", W'(in_ready), 0);
    drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 4'd9);  // must be ignored
    cycle();
    check("bp_hold_tag", W'(tag_out), 1);
    check("bp_hold_valid", W'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("bp_second_tag", W'(tag_out), 2);
    check("bp_in_ready_back", W'(in_ready), 1);
    cycle();
    check("bp_drained", W'(out_valid), 0);

    // Streaming: 16 beats back to back
    base = n_sent;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
            1'(i & 1), 1'($urandom_range(0, 1)), 4'(i));
      cycle();
      check("stream_in_ready", W'(in_ready), 1);
      check("stream_out_valid", W'(out_valid), 1);
    end
    in_valid = 1'b0;
    cycle();
    check("stream_count", W'(n_sent - base), 16);
    check("stream_empty", W'(out_valid), 0);

    // Async reset while both registers are full
    out_ready = 1'b0;
    drive(1'b1, 64'hAAAA, 64'h5555, 1'b0, 1'b0, 4'd10);
    cycle();
    drive(1'b1, 64'hBBBB, 64'h4444, 1'b1, 1'b0, 4'd11);
    cycle();
    check("rst_pre_full", W'(in_ready), 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = n_sent;
    drive(1'b1, 64'h77, 64'h7, 1'b0, 1'b1, 4'd7);
    cycle();
    check("post_rst_tag", W'(tag_out), 7);
    check("post_rst_valid", W'(out_valid), 1);
    in_valid = 1'b0;
    cycle();
    check("post_rst_alone", W'(out_valid), 0);
    check("post_rst_count", W'(n_sent - base), 1);

    // Random valid/ready, 10k beats
    base = n_acc;
    cyc  = 0;
    while ((n_acc - base) < 10000 && cyc < 60000) begin
      drive(1'($urandom_range(0, 9) < 7), {$urandom(), $urandom()},
            {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      out_ready = 1'($urandom_range(0, 9) < 7);
      cycle();
      cyc++;
    end
    check("rand_accept_count", W'(n_acc - base), 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (out_valid && cyc < 4) begin
      cycle();
      cyc++;
    end
    check("rand_drained", W'(out_valid), 0);
    check("rand_sb_empty", W'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
